tick_generator: RTL and testbench
=================================

TICK_GENERATOR -- requirements
Module: tick_generator

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent tick channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 27: divisor and counter width in bits.
REQ-003 SHALL have parameter DEF_DIV, default {NUM_CH{27'd100_000_000}}: packed NUM_CH*CNT_W per-channel reset divisors; channel i in bits [i*CNT_W +: CNT_W].
REQ-004 SHALL have the following ports:
- M_CLK  input  1  master clock; the only clock; all state on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- PAUSE  input  1  global freeze of all channels.
- RESTART  input  NUM_CH  per-channel synchronous restart.
- CFG_WE  input  1  divisor write strobe.
- CFG_CH  input  4  channel index for the write.
- CFG_DIV  input  CNT_W  divisor value for the write.
- TICK  output  NUM_CH  per-channel single-cycle enable pulse.
- SQ_CLK  output  NUM_CH  per-channel square wave; toggles on every tick.
- ACTIVE_DIV  output  CNT_W  active divisor of channel CFG_CH (readback); 0 if CFG_CH >= NUM_CH.

Function
REQ-005 Each channel SHALL hold a shadow divisor (SHD), an active divisor (ACT), a counter CNT, and registered TICK and SQ_CLK bits.
REQ-006 Effective divisor E = max(ACT,1): a divisor of 0 SHALL behave as 1.
REQ-007 Per channel, per edge, priority RESTART > PAUSE > count:
- RESTART[i]=1: CNT<=0, TICK[i]<=0, SQ_CLK[i]<=0, ACT<=next SHD (see REQ-010).
- else PAUSE=1: CNT, ACT, SQ_CLK[i] hold; TICK[i]<=0.
- else CNT >= E-1: CNT<=0, TICK[i]<=1, SQ_CLK[i]<=~SQ_CLK[i], ACT<=next SHD.
- else: CNT<=CNT+1, TICK[i]<=0.
REQ-008 Counting SHALL produce TICK[i] high exactly one cycle in every E enabled cycles; first TICK after reset release or RESTART is registered on the E-th enabled edge.
REQ-009 SQ_CLK[i] SHALL have period 2*E cycles, 50% duty, with transitions aligned to the edge that raises TICK[i].
REQ-010 CFG_WE=1 with CFG_CH<NUM_CH SHALL write CFG_DIV into SHD of that channel. If that channel wraps or restarts on the same edge, ACT SHALL take CFG_DIV (write bypass). Otherwise the new value reaches ACT at the next wrap/restart; the current period is never truncated.
REQ-011 CFG_WE with CFG_CH >= NUM_CH SHALL be ignored with no state change.
REQ-012 Lowering ACT below CNT+1 SHALL NOT occur mid-period, since ACT changes only at wrap/restart; the >= comparison SHALL still force a wrap on the next enabled edge.
REQ-013 Channels SHALL be fully independent; RESTART of one SHALL not disturb others.
REQ-014 ACTIVE_DIV SHALL be combinational from CFG_CH and ACT.
REQ-015 All arithmetic SHALL be unsigned CNT_W-bit; CNT SHALL never exceed E-1 except transiently via REQ-012.

Reset
REQ-016 RST=1 SHALL asynchronously set, per channel: CNT=0, SHD=ACT=DEF_DIV slice, TICK=0, SQ_CLK=0.
REQ-017 RST held high SHALL keep all outputs at reset values regardless of other inputs; counting SHALL resume on the first edge after deassertion.
REQ-018 RST asserted mid-period SHALL discard any pending SHD write; divisors SHALL revert to DEF_DIV.

Verification
REQ-019 DEF_DIV={4,3,1,0}, release RST -> ch0 TICK on edges 4,8,12; ch1 on 3,6,9; ch2 and ch3 every edge; SQ_CLK0 period 8.
REQ-020 ch0 div 4; write CFG_DIV=6 to ch0 at edge 2 -> ticks at 4 (old period), then 10, 16; ACTIVE_DIV reads 4 until edge 4, then 6.
REQ-021 ch1 div 3; write CFG_DIV=5 on the same edge ch1 wraps (edge 3) -> next ticks at 8, 13 (bypass).
REQ-022 PAUSE high for edges 2-5 with div 4 -> no TICK during pause, first TICK at edge 8; SQ_CLK unchanged while paused; RESTART[0] during PAUSE -> CNT=0, SQ_CLK0=0.
REQ-023 RESTART[1] pulse mid-period -> TICK[1] on the E-th edge after it; ch0 tick sequence unchanged; CFG_CH=7 with NUM_CH=4 write -> no change anywhere.
REQ-024 Assert RST asynchronously between edges mid-count -> TICK, SQ_CLK, CNT clear immediately without a clock edge; DEF_DIV restored.

Source files
------------

// File: rtl/tick_generator.sv
// tick_generator: per-channel programmable tick/square-wave generator with shadowed divisors
module tick_generator #(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 27,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {NUM_CH{27'd100_000_000}}
) (
    input  logic              M_CLK,
    input  logic              RST,
    input  logic              PAUSE,
    input  logic [NUM_CH-1:0] RESTART,
    input  logic              CFG_WE,
    input  logic [3:0]        CFG_CH,
    input  logic [CNT_W-1:0]  CFG_DIV,
    output logic [NUM_CH-1:0] TICK,
    output logic [NUM_CH-1:0] SQ_CLK,
    output logic [CNT_W-1:0]  ACTIVE_DIV
);
    // Full 16-entry readback table so any CFG_CH indexes in range; absent channels read 0
    logic [CNT_W-1:0] act_rd [16];
    for (genvar i = 0; i < 16; i++) begin : g_ch
        if (i < NUM_CH) begin : g_on
            logic [CNT_W-1:0] shd, act, cnt, shd_nxt, eff;
            logic tick, sq;
            assign shd_nxt = (CFG_WE && CFG_CH == 4'(i)) ? CFG_DIV : shd;
            assign eff = (act == '0) ? CNT_W'(1) : act;
            always_ff @(posedge M_CLK or posedge RST) begin
                if (RST) begin
                    cnt  <= '0;
                    shd  <= DEF_DIV[i*CNT_W +: CNT_W];
                    act  <= DEF_DIV[i*CNT_W +: CNT_W];
                    tick <= 1'b0;
                    sq   <= 1'b0;
                end else begin
                    shd <= shd_nxt;
                    if (RESTART[i]) begin
                        cnt  <= '0;
                        tick <= 1'b0;
                        sq   <= 1'b0;
                        act  <= shd_nxt;
                    end else if (PAUSE) begin
                        tick <= 1'b0;
                    end else if (cnt >= eff - CNT_W'(1)) begin
                        cnt  <= '0;
                        tick <= 1'b1;
                        sq   <= ~sq;
                        act  <= shd_nxt;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        tick <= 1'b0;
                    end
                end
            end
            assign TICK[i]   = tick;
            assign SQ_CLK[i] = sq;
            assign act_rd[i] = act;
        end else begin : g_off
            assign act_rd[i] = '0;
        end
    end
    assign ACTIVE_DIV = act_rd[CFG_CH];
endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: randomized scoreboard bench against a countdown reference model
module tb_tick_generator;
    localparam int NUM_CH = 4;
    localparam int CNT_W = 8;
    localparam logic [NUM_CH*CNT_W-1:0] DEF = {8'd0, 8'd1, 8'd3, 8'd4};

    logic M_CLK = 1'b0;
    logic RST = 1'b1;
    logic PAUSE = 1'b0;
    logic [NUM_CH-1:0] RESTART = '0;
    logic CFG_WE = 1'b0;
    logic [3:0] CFG_CH = '0;
    logic [CNT_W-1:0] CFG_DIV = '0;
    logic [NUM_CH-1:0] TICK, SQ_CLK;
    logic [CNT_W-1:0] ACTIVE_DIV;

    tick_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF)) dut (
        .M_CLK(M_CLK), .RST(RST), .PAUSE(PAUSE), .RESTART(RESTART),
        .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_DIV(CFG_DIV),
        .TICK(TICK), .SQ_CLK(SQ_CLK), .ACTIVE_DIV(ACTIVE_DIV)
    );

    always #5 M_CLK = ~M_CLK;

    typedef struct packed {
        logic [NUM_CH-1:0] t;
        logic [NUM_CH-1:0] s;
        logic [CNT_W-1:0]  a;
    } exp_t;
    exp_t q[$];

    int defv[NUM_CH] = '{4, 3, 1, 0};
    int shd[NUM_CH], act[NUM_CH], left[NUM_CH];
    bit mt[NUM_CH], ms[NUM_CH];
    int n_cmp = 0, n_err = 0;

    function automatic int eff(int d);
        return d == 0 ? 1 : d;
    endfunction

    // Reference: each channel counts down the enabled edges remaining until its next tick
    always @(posedge M_CLK or posedge RST) begin
        exp_t e;
        if (RST) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shd[c] = defv[c]; act[c] = defv[c]; left[c] = eff(defv[c]);
                mt[c] = 0; ms[c] = 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (CFG_WE && int'(CFG_CH) == c) shd[c] = int'(CFG_DIV);
                if (RESTART[c]) begin
                    act[c] = shd[c]; left[c] = eff(act[c]); mt[c] = 0; ms[c] = 0;
                end else if (PAUSE) begin
                    mt[c] = 0;
                end else begin
                    left[c]--;
                    mt[c] = (left[c] == 0);
                    if (mt[c]) begin
                        ms[c] = !ms[c]; act[c] = shd[c]; left[c] = eff(act[c]);
                    end
                end
            end
        end
        if (M_CLK === 1'b1) begin
            for (int c = 0; c < NUM_CH; c++) begin
                e.t[c] = mt[c]; e.s[c] = ms[c];
            end
            e.a = (int'(CFG_CH) < NUM_CH) ? CNT_W'(act[CFG_CH]) : '0;
            q.push_back(e);
        end
    end

    // Monitor: edge-driven scoreboard pops, plus immediate check after an async reset between edges
    initial begin
        exp_t e, got;
        forever begin
            @(posedge M_CLK or posedge RST);
            #1;
            got = {TICK, SQ_CLK, ACTIVE_DIV};
            if (RST && !M_CLK) begin
                e.t = '0; e.s = '0;
                e.a = (int'(CFG_CH) < NUM_CH) ? CNT_W'(defv[CFG_CH]) : '0;
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL async_rst t=%0t got tick=%b sq=%b div=%0d want tick=%b sq=%b div=%0d",
                             $time, got.t, got.s, got.a, e.t, e.s, e.a);
                end
            end else if (M_CLK) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_empty t=%0t got tick=%b want a queued entry", $time, got.t);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL sb t=%0t got tick=%b sq=%b div=%0d want tick=%b sq=%b div=%0d",
                                 $time, got.t, got.s, got.a, e.t, e.s, e.a);
                    end
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge M_CLK);
    endtask

    task automatic rst_release();
        RST = 1'b1; cyc(2); RST = 1'b0;
    endtask

    initial begin
        cyc(3);
        RST = 1'b0;
        cyc(16);
        rst_release();
        cyc(1);
        CFG_WE = 1'b1; CFG_CH = 4'd0; CFG_DIV = 8'd6; cyc(1);
        CFG_CH = 4'd1; CFG_DIV = 8'd5; cyc(1);
        CFG_WE = 1'b0; CFG_CH = 4'd0; cyc(4);
        CFG_CH = 4'd1; cyc(16);
        rst_release();
        CFG_CH = 4'd0;
        cyc(1);
        PAUSE = 1'b1; cyc(4);
        PAUSE = 1'b0; cyc(10);
        PAUSE = 1'b1; RESTART = 4'b0001; cyc(1);
        RESTART = '0; PAUSE = 1'b0; cyc(5);
        RESTART = 4'b0010; cyc(1);
        RESTART = '0; cyc(6);
        CFG_WE = 1'b1; CFG_CH = 4'd7; CFG_DIV = 8'd2; cyc(1);
        CFG_WE = 1'b0; cyc(10);
        CFG_CH = 4'd0;
        CFG_WE = 1'b1; CFG_DIV = 8'd9; cyc(1);
        CFG_WE = 1'b0; cyc(2);
        #2 RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            PAUSE   = ($urandom_range(0, 7) == 0);
            RESTART = ($urandom_range(0, 15) == 0) ? 4'($urandom) : '0;
            CFG_WE  = ($urandom_range(0, 3) == 0);
            CFG_CH  = 4'($urandom_range(0, 7));
            CFG_DIV = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 299) == 0) begin
                #2 RST = 1'b1;
                cyc(1);
                RST = 1'b0;
            end else begin
                cyc(1);
            end
        end
        PAUSE = 1'b0; RESTART = '0; CFG_WE = 1'b0;
        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
